// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the mode codes and the two-state sequencer encoding.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/usr_barrel.sv
// Combinational rotate-right, rotate-left and arithmetic-right-shift by amt.
// Ports: d (data), amt (shift amount) -> ror_q, rol_q, asr_q.
module usr_barrel
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] ror_q,
    output logic [WIDTH-1:0] rol_q,
    output logic [WIDTH-1:0] asr_q
);

    // Rotates wrap modulo WIDTH; only matters when WIDTH is not a power of two.
    logic [31:0] sh;

    assign sh = 32'(amt) % 32'(WIDTH);

    // Rotation via a doubled copy of the word: the window slides across it.
    assign ror_q = WIDTH'({d, d} >> sh);
    assign rol_q = WIDTH'(({d, d} << sh) >> WIDTH);

    // Shifting by WIDTH or more naturally yields all sign bits.
    assign asr_q = WIDTH'($signed(d) >>> amt);

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with a parallel-in serial-out burst.
// Ports: clk, rst (async active-low), en, mode, amt, sin_r, sin_l, par_in
//        -> q, sout (=q[0]), sout_valid (=busy), busy, done (1-cycle pulse).
module usr_param
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [$clog2(WIDTH)-1:0] amt,
    input  logic                     sin_r,
    input  logic                     sin_l,
    input  logic [WIDTH-1:0]         par_in,
    output logic [WIDTH-1:0]         q,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q_n;
    logic             done_n;

    logic [WIDTH-1:0] ror_q, rol_q, asr_q;

    usr_barrel #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_barrel (
        .d     (q),
        .amt   (amt),
        .ror_q (ror_q),
        .rol_q (rol_q),
        .asr_q (asr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q     <= RESET_VAL;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        done_n  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    unique case (mode)
                        MODE_HOLD:  q_n = q;
                        MODE_SHR:   q_n = {sin_r, q[WIDTH-1:1]};
                        MODE_SHL:   q_n = {q[WIDTH-2:0], sin_l};
                        MODE_LOAD:  q_n = par_in;
                        MODE_ROR:   q_n = ror_q;
                        MODE_ROL:   q_n = rol_q;
                        MODE_ASR:   q_n = asr_q;
                        MODE_BURST: begin
                            q_n     = par_in;
                            cnt_n   = '0;
                            state_n = ST_STREAM;
                        end
                        default:    q_n = q;
                    endcase
                end
            end
            ST_STREAM: begin
                // Commands are ignored; only reset can abort a burst.
                q_n   = {sin_r, q[WIDTH-1:1]};
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy       = (state == ST_STREAM);
    assign sout_valid = busy;
    assign sout       = q[0];

endmodule
